// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: IDLE -> ACCESS -> DONE, fixed two-cycle latency.
// Optional macro ARB_ROUND_ROBIN_EN alternates ties; otherwise requester 0 always wins ties.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wrt,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_r;
    logic          win_id_r;
    logic          we_r;
    logic          last_grant_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;
    logic          ack0_r;
    logic          ack1_r;
    logic          rd_r;
    logic          wrt_r;
    logic          busy_r;
    logic          grant_s;
    logic          grant_we_s;

    // Winner selection; on a tie requester 1 wins only when alternation is enabled and 0 went last
    always_comb begin
        grant_s    = 1'b0;
        grant_we_s = 1'b0;
        if (req0) begin
            grant_s = req1 & ~last_grant_r & RR_EN;
        end else begin
            grant_s = 1'b1;
        end
        if (grant_s) begin
            grant_we_s = we1;
        end else begin
            grant_we_s = we0;
        end
    end

    // Transaction sequencer; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            win_id_r     <= 1'b0;
            we_r         <= 1'b0;
            last_grant_r <= 1'b1;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            rdata0_r     <= {DW{1'b0}};
            rdata1_r     <= {DW{1'b0}};
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rd_r         <= 1'b0;
            wrt_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    if (req0 || req1) begin
                        win_id_r     <= grant_s;
                        last_grant_r <= grant_s;
                        we_r         <= grant_we_s;
                        addr_r       <= grant_s ? addr1 : addr0;
                        wdata_r      <= grant_s ? wdata1 : wdata0;
                        rd_r         <= ~grant_we_s;
                        wrt_r        <= grant_we_s;
                        busy_r       <= 1'b1;
                        state_r      <= ACCESS;
                    end else begin
                        rd_r    <= 1'b0;
                        wrt_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    rd_r  <= 1'b0;
                    wrt_r <= 1'b0;
                    if (!we_r) begin
                        if (win_id_r) begin
                            rdata1_r <= mem_rdata;
                        end else begin
                            rdata0_r <= mem_rdata;
                        end
                    end
                    ack0_r  <= ~win_id_r;
                    ack1_r  <= win_id_r;
                    state_r <= DONE;
                end
                DONE: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    rd_r    <= 1'b0;
                    wrt_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Reset forces outputs low immediately so an aborted write never reaches the RAM edge
    assign ack0      = ack0_r & ~rst;
    assign ack1      = ack1_r & ~rst;
    assign mem_rd    = rd_r & ~rst;
    assign mem_wrt   = wrt_r & ~rst;
    assign busy      = busy_r & ~rst;
    assign mem_addr  = rst ? {AW{1'b0}} : addr_r;
    assign mem_wdata = rst ? {DW{1'b0}} : wdata_r;
    assign rdata0    = rst ? {DW{1'b0}} : rdata0_r;
    assign rdata1    = rst ? {DW{1'b0}} : rdata1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM model.
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
    logic       ack0, ack1, mem_rd, mem_wrt, busy;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic [7:0] ram [0:255];
    int         errors = 0;
    int         checks = 0;

    mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_wrt) ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    logic exp_order [4];
    logic got_order [4];
    int   n_acks;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h80] = 8'h44;
        ram[8'h90] = 8'h3C;
        ram[8'h92] = 8'h77;
        ram[8'hFF] = 8'hA5;

        // Reset values
        next_cycle();
        mid();
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {mem_rd, mem_wrt, ack0, ack1}, 4'b0000);
        check("rst_data", {mem_addr, mem_wdata, rdata0, rdata1}, 32'h0);
        next_cycle();
        rst = 1'b0;

        // Idle with no request
        mid();
        check("idle_quiet", {busy, mem_rd, mem_wrt, ack0, ack1}, 5'b00000);

        // Read from port 0
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h80;
        next_cycle();
        req0 = 1'b0;
        mid();
        check("rd_c1_strobes", {mem_rd, mem_wrt, busy, ack0}, 4'b1010);
        check("rd_c1_addr", mem_addr, 8'h80);
        next_cycle();
        mid();
        check("rd_c2_ack", {ack0, ack1, mem_rd}, 3'b100);
        check("rd_c2_rdata0", rdata0, 8'h44);
        next_cycle();
        mid();
        check("rd_c3_idle", {busy, ack0}, 2'b00);

        // Write from port 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h81; wdata1 = 8'h55;
        next_cycle();
        req1 = 1'b0;
        mid();
        check("wr_c1_strobes", {mem_wrt, mem_rd}, 2'b10);
        check("wr_c1_addr_data", {mem_addr, mem_wdata}, 16'h8155);
        next_cycle();
        mid();
        check("wr_c2_ack", {ack1, ack0, mem_wrt}, 3'b100);
        check("wr_ram", ram[8'h81], 8'h55);
        check("wr_rdata0_hold", rdata0, 8'h44);
        check("wr_rdata1_hold", rdata1, 8'h00);

        // Address FF read on port 1 passes through unchanged
        next_cycle();
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
        next_cycle();
        req1 = 1'b0;
        mid();
        check("ff_addr", mem_addr, 8'hFF);
        next_cycle();
        mid();
        check("ff_rdata1", {ack1, rdata1}, 9'h1A5);
        next_cycle();

        // Tie arbitration over four transactions
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h80; addr1 = 8'h90;
        n_acks = 0;
        for (int c = 0; c < 40 && n_acks < 4; c++) begin
            mid();
            if (ack0 && ack1) check("ack_exclusive", {ack0, ack1}, 2'b10);
            else if (ack0) begin got_order[n_acks] = 1'b0; n_acks++; end
            else if (ack1) begin got_order[n_acks] = 1'b1; n_acks++; end
            next_cycle();
        end
        check("tie_ack_count", n_acks, 4);
        for (int k = 0; k < n_acks; k++) check($sformatf("tie_order%0d", k), got_order[k], exp_order[k]);
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 0; c < 4; c++) next_cycle();

        // Reset during ACCESS of a write aborts it
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'hF0; wdata0 = 8'hAA;
        next_cycle();
        req0 = 1'b0; we0 = 1'b0;
        rst = 1'b1;
        mid();
        check("abort_strobes", {mem_wrt, mem_rd, ack0, busy}, 4'b0000);
        next_cycle();
        rst = 1'b0;
        mid();
        check("abort_idle", {busy, ack0, ack1, mem_wrt}, 4'b0000);
        check("abort_ram", ram[8'hF0], 8'h00);
        next_cycle();
        mid();
        check("abort_no_late_ack", {ack0, busy}, 2'b00);

        // Inputs changed after grant are ignored
        next_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h90;
        next_cycle();
        req0 = 1'b0; addr0 = 8'h92;
        mid();
        check("late_addr", {mem_rd, mem_addr}, 9'h190);
        next_cycle();
        mid();
        check("late_ack", {ack0, rdata0}, 9'h13C);
        next_cycle();
        mid();
        check("late_ack_once", {ack0, busy}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, memory address width in bits.
REQ-002 Parameter DW, default 8, memory data width in bits.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req0, req1  input  1 each  access request from requester 0 (processor) and requester 1 (loader).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read, for the matching requester.
REQ-007 addr0, addr1  input  AW each  target address for the matching requester.
REQ-008 wdata0, wdata1  input  DW each  write data for the matching requester.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse to the matching requester.
REQ-010 rdata0, rdata1  output  DW each  read data, valid while the matching ack is high.
REQ-011 mem_addr  output  AW, mem_wdata  output  DW  address and write data to the single-port RAM.
REQ-012 mem_rd, mem_wrt  output  1 each  RAM read and write strobes, never both high.
REQ-013 mem_rdata  input  DW  RAM read data, valid in the same cycle as mem_rd.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM shall have three states, IDLE, ACCESS and DONE, and advance only on the rising clk edge.
REQ-016 In IDLE with any reqN high, the block shall latch the winner's id, we, addr and wdata and move to ACCESS on the next edge.
REQ-017 In IDLE with no request, the FSM shall stay in IDLE and all strobes and acks shall be 0.
REQ-018 In ACCESS, mem_addr and mem_wdata shall carry the latched values, and exactly one of mem_rd or mem_wrt shall be high, selected by the latched we; the FSM shall then move to DONE.
REQ-019 On a read, mem_rdata shall be captured at the end of the ACCESS cycle into the winner's rdata register.
REQ-020 In DONE, the winner's ack shall be high for exactly one cycle; the FSM shall then return to IDLE.
REQ-021 Latency shall be fixed: a request first sampled in cycle N produces ack in cycle N+2; the next grant is possible at cycle N+3.
REQ-022 rdataN shall hold its last captured value until that port's next read completes.
REQ-023 A request that drops during ACCESS or DONE shall still complete and still receive its ack.
REQ-024 Requester inputs shall be sampled only in IDLE; changes made after the grant shall be ignored.
REQ-025 ack0 and ack1 shall never be high in the same cycle.
REQ-026 The losing requester shall keep req high and shall be granted in a later IDLE cycle.
REQ-027 The last_grant register shall be updated to the winner's id at each grant.
REQ-028 Address wrap: no address arithmetic is performed; 8'hFF shall be passed to the RAM unchanged.

Reset
REQ-029 With rst high at an edge, the next state shall be IDLE and last_grant shall be 1, so requester 0 wins the first tie.
REQ-030 During reset, ack0, ack1, mem_rd, mem_wrt and busy shall be 0, and mem_addr, mem_wdata, rdata0 and rdata1 shall be 0.
REQ-031 A reset during ACCESS or DONE shall abort the transaction: no ack, strobes low after the edge, and any partial write discarded.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN, when defined: on simultaneous requests in IDLE, grant the requester not equal to last_grant.
REQ-033 Macro ARB_ROUND_ROBIN_EN, when undefined: requester 0 always wins ties; last_grant is still maintained but does not affect the decision.

Verification
REQ-034 Reset, then req0=1, we0=0, addr0=8'h80, RAM[80h]=8'h44 -> mem_rd high in cycle 1, ack0 and rdata0=8'h44 in cycle 2, busy low in cycle 3.
REQ-035 req1=1, we1=1, addr1=8'h81, wdata1=8'h55 -> mem_wrt high for exactly one cycle with mem_addr=8'h81, then ack1; RAM[81h]=8'h55.
REQ-036 req0 and req1 held high together for 4 transactions -> with ARB_ROUND_ROBIN_EN, ack order 0,1,0,1; without it, 0,0,0,0.
REQ-037 rst asserted during ACCESS of a write to 8'hF0 (RAM[F0h]=8'h00) -> no ack, RAM[F0h] stays 8'h00, FSM in IDLE after one cycle.
REQ-038 req0 dropped one cycle after its grant, addr0 changed to 8'h92 -> the access still uses the original address and ack0 still pulses once.
